sar_divider_arbiter: RTL and testbench

Round-robin scheduler that shares one `sar_divisor_module` instance between `N_REQ` requesters. It accepts one division job at a time over a valid/ready handshake, sequences the divider's reset/start and `ready` completion, and returns the quotient on a shared response bus tagged with the requester id. Divide-by-zero is short-circuited without using the divider, and a watchdog bounds every divider run.

---
 rtl/sar_divider_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sar_divider_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_divider_arbiter.sv
// Round-robin front end for a single shared SAR divider.
// Accepts one job at a time, sequences the divider's reset/start and completion,
// short-circuits divide-by-zero and bounds every divider run with a watchdog.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. valid, once raised, is held until that edge; the payload
// is stable while valid is high. req_ready is combinational from req_valid
// and is asserted only in IDLE. rsp_ready may be high before rsp_valid.
module sar_divider_arbiter #(
  parameter int BITS       = 40,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*BITS-1:0] req_dividend,
  input  logic [N_REQ*BITS-1:0] req_divisor,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [BITS-1:0]       rsp_result,
  output logic [1:0]            rsp_status,
  output logic                  busy,
  output logic [BITS-1:0]       div_dividendo,
  output logic [BITS-1:0]       div_divisor,
  output logic                  div_reset,
  input  logic [BITS-1:0]       div_result,
  input  logic                  div_ready,
  output logic [1:0]            state_dbg
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_DIVZERO = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [BITS-1:0]   dividend_q, dividend_d;
  logic [BITS-1:0]   divisor_q, divisor_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [BITS-1:0]   result_q, result_d;
  logic [1:0]        status_q, status_d;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_d;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_d;

  logic              found;
  logic [ID_W-1:0]   gidx;
  logic [N_REQ-1:0]  grant_oh;
  logic [BITS-1:0]   sel_dividend;
  logic [BITS-1:0]   sel_divisor;

  // Rotating-priority search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found = 1'b1;
        gidx  = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
    grant_oh     = found ? (N_REQ'(1) << gidx) : '0;
    sel_dividend = req_dividend[int'(gidx)*BITS +: BITS];
    sel_divisor  = req_divisor[int'(gidx)*BITS +: BITS];
  end

  // Next-state and datapath update; every register holds unless a state acts on it.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    id_d       = id_q;
    result_d   = result_q;
    status_d   = status_q;
    rst_cnt_d  = rst_cnt;
    wd_cnt_d   = wd_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          rr_ptr_d   = (int'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);
          dividend_d = sel_dividend;
          divisor_d  = sel_divisor;
          id_d       = gidx;
          if (sel_divisor == '0) begin
            // The divider is never started for a zero divisor.
            result_d = '1;
            status_d = ST_DIVZERO;
            state_d  = RESP;
          end else begin
            rst_cnt_d = '0;
            state_d   = LOAD;
          end
        end
      end
      LOAD: begin
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
          wd_cnt_d = '0;
          state_d  = RUN;
        end else begin
          rst_cnt_d = rst_cnt + RC_W'(1);
        end
      end
      RUN: begin
        if (div_ready) begin
          result_d = div_result;
          status_d = ST_OK;
          state_d  = RESP;
        end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
          result_d = '0;
          status_d = ST_TIMEOUT;
          state_d  = RESP;
        end else begin
          wd_cnt_d = wd_cnt + WD_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      id_q       <= '0;
      result_q   <= '0;
      status_q   <= ST_OK;
      rst_cnt    <= '0;
      wd_cnt     <= '0;
    end else begin
      state      <= state_d;
      rr_ptr     <= rr_ptr_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      id_q       <= id_d;
      result_q   <= result_d;
      status_q   <= status_d;
      rst_cnt    <= rst_cnt_d;
      wd_cnt     <= wd_cnt_d;
    end
  end

  // The divider is held in reset everywhere except RUN, so it idles cleared.
  assign req_ready     = (state == IDLE && reset) ? grant_oh : '0;
  assign rsp_valid     = (state == RESP);
  assign rsp_id        = id_q;
  assign rsp_result    = result_q;
  assign rsp_status    = status_q;
  assign busy          = (state != IDLE);
  assign div_dividendo = dividend_q;
  assign div_divisor   = divisor_q;
  assign div_reset     = (state != RUN);
  assign state_dbg     = state;

endmodule

// File: tb/tb_sar_divider_arbiter.sv
// Directed bench for sar_divider_arbiter with a behavioural divider stub.
module tb_sar_divider_arbiter;

  localparam int BITS       = 40;
  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int RST_CYCLES = 2;
  localparam int TIMEOUT    = 64;
  localparam int LAT        = 5;
  localparam int EW         = 2 + ID_W + BITS;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*BITS-1:0] req_dividend;
  logic [N_REQ*BITS-1:0] req_divisor;
  logic [N_REQ-1:0]      req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [BITS-1:0]       rsp_result;
  logic [1:0]            rsp_status;
  logic                  busy;
  logic [BITS-1:0]       div_dividendo;
  logic [BITS-1:0]       div_divisor;
  logic                  div_reset;
  logic [BITS-1:0]       div_result;
  logic                  div_ready;
  logic [1:0]            state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic stuck = 1'b0;
  logic [3:0] stub_cnt;
  logic saw_run;
  int rr_res[4] = '{100, 50, 33, 25};

  sar_divider_arbiter #(
    .BITS(BITS), .N_REQ(N_REQ), .ID_W(ID_W),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_status(rsp_status), .busy(busy),
    .div_dividendo(div_dividendo), .div_divisor(div_divisor), .div_reset(div_reset),
    .div_result(div_result), .div_ready(div_ready), .state_dbg(state_dbg)
  );

  // Clock and global time limit
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Divider stub: cleared while div_reset is high, answers LAT cycles into a run.
  always @(posedge clk) begin
    if (div_reset) stub_cnt <= '0;
    else if (stub_cnt < 4'(LAT)) stub_cnt <= stub_cnt + 4'd1;
  end
  assign div_ready  = !div_reset && (stub_cnt == 4'(LAT)) && !stuck;
  assign div_result = (div_divisor == '0) ? '0 : div_dividendo / div_divisor;

  // Records any cycle in which the divider was released from reset.
  always @(negedge clk) if (!div_reset) saw_run <= 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    req_dividend[i*BITS +: BITS] = a;
    req_divisor[i*BITS +: BITS]  = b;
  endtask

  task automatic push_exp(input logic [1:0] st, input logic [ID_W-1:0] id, input logic [BITS-1:0] res);
    exp_q.push_back({st, id, res});
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    stuck     = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge after driving; returns on the accept edge.
  task automatic wait_grant(input string tag, input logic [N_REQ-1:0] exp_oh);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 64'(req_ready), 64'(exp_oh));
    @(posedge clk);
  endtask

  task automatic check_rsp(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_expq"}, 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"},  64'(rsp_valid),  64'(1));
      check({tag, "_id"},     64'(rsp_id),     64'(e[BITS +: ID_W]));
      check({tag, "_result"}, 64'(rsp_result), 64'(e[BITS-1:0]));
      check({tag, "_status"}, 64'(rsp_status), 64'(e[EW-1 -: 2]));
    end
  endtask

  // Waits from the accept edge to the first negedge with rsp_valid high.
  task automatic wait_resp(input string tag, output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_rsp(tag);
  endtask

  initial begin
    int n;
    int m;
    req_dividend = '0;
    req_divisor  = '0;
    req_valid    = '0;
    rsp_ready    = 1'b0;
    reset        = 1'b0;

    // Reset values
    #1;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_result", 64'(rsp_result), 64'(0));
    check("rst_rsp_status", 64'(rsp_status), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_div_reset", 64'(div_reset), 64'(1));
    check("rst_div_ops", 64'({div_dividendo, div_divisor} != '0), 64'(0));
    check("rst_state", 64'(state_dbg), 64'(0));

    // Single job: 425332234 / 62254 = 6832
    do_reset();
    rsp_ready = 1'b1;
    set_op(0, 40'd425332234, 40'd62254);
    req_valid = 4'b0001;
    push_exp(2'b00, 2'd0, 40'd6832);
    wait_grant("single_grant", 4'b0001);
    @(negedge clk);
    req_valid = '0;
    check("single_t1_div_reset", 64'(div_reset), 64'(1));
    check("single_t1_busy", 64'(busy), 64'(1));
    check("single_t1_req_ready", 64'(req_ready), 64'(0));
    check("single_t1_ops", 64'(div_dividendo), 64'(425332234));
    @(negedge clk);
    check("single_t2_div_reset", 64'(div_reset), 64'(1));
    @(negedge clk);
    check("single_t3_div_reset", 64'(div_reset), 64'(0));
    check("single_t3_divisor", 64'(div_divisor), 64'(62254));
    wait_resp("single_rsp", n);
    @(negedge clk);
    check("single_after_valid", 64'(rsp_valid), 64'(0));
    check("single_after_busy", 64'(busy), 64'(0));

    // Round robin: 100/k on all four, grants 0,1,2,3,0
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 40'd100, 40'(i + 1));
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      push_exp(2'b00, ID_W'(j % 4), 40'(rr_res[j % 4]));
      wait_grant($sformatf("rr_grant%0d", j), 4'(1 << (j % 4)));
      wait_resp($sformatf("rr_rsp%0d", j), n);
    end
    // rr_ptr now 1: req1 first, then with rr_ptr at 2 req3 wins over req1
    req_valid = 4'b1010;
    push_exp(2'b00, 2'd1, 40'd50);
    wait_grant("rr13_grant_a", 4'b0010);
    wait_resp("rr13_rsp_a", n);
    push_exp(2'b00, 2'd3, 40'd25);
    wait_grant("rr13_grant_b", 4'b1000);
    wait_resp("rr13_rsp_b", n);
    req_valid = '0;

    // Divide-by-zero: req2 77/0
    do_reset();
    saw_run = 1'b0;
    set_op(2, 40'd77, 40'd0);
    req_valid = 4'b0100;
    push_exp(2'b01, 2'd2, 40'hFF_FFFF_FFFF);
    wait_grant("div0_grant", 4'b0100);
    wait_resp("div0_rsp", n);
    check("div0_latency", 64'(n), 64'(0));
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("div0_after_valid", 64'(rsp_valid), 64'(0));
    check("div0_never_run", 64'(saw_run), 64'(0));

    // Backpressure: req1 response held 10 cycles while req0 waits
    do_reset();
    set_op(1, 40'd1000, 40'd10);
    req_valid = 4'b0010;
    push_exp(2'b00, 2'd1, 40'd100);
    wait_grant("bp_grant1", 4'b0010);
    @(negedge clk);
    set_op(0, 40'd50, 40'd5);
    req_valid = 4'b0001;
    wait_resp("bp_rsp1", n);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_ctl", c),
            64'({rsp_valid, busy, req_ready, rsp_id, rsp_status}),
            64'({1'b1, 1'b1, 4'b0000, 2'd1, 2'b00}));
      check($sformatf("bp_hold%0d_result", c), 64'(rsp_result), 64'(100));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_after_valid", 64'(rsp_valid), 64'(0));
    check("bp_after_req_ready", 64'(req_ready), 64'(4'b0001));
    push_exp(2'b00, 2'd0, 40'd10);
    wait_grant("bp_grant0", 4'b0001);
    wait_resp("bp_rsp0", n);
    req_valid = '0;

    // Timeout: divider never answers, then a normal job
    do_reset();
    stuck = 1'b1;
    rsp_ready = 1'b1;
    set_op(0, 40'd9, 40'd3);
    req_valid = 4'b0001;
    push_exp(2'b10, 2'd0, 40'd0);
    wait_grant("to_grant", 4'b0001);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (div_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    m = 0;
    while (!rsp_valid && m < 200) begin
      @(negedge clk);
      m++;
    end
    check("to_latency", 64'(m), 64'(TIMEOUT));
    check_rsp("to_rsp");
    stuck = 1'b0;
    set_op(0, 40'd81, 40'd9);
    req_valid = 4'b0001;
    push_exp(2'b00, 2'd0, 40'd9);
    wait_grant("to_next_grant", 4'b0001);
    wait_resp("to_next_rsp", n);
    req_valid = '0;

    // Reset during RUN: job dropped, rr_ptr restarts at 0
    do_reset();
    rsp_ready = 1'b1;
    set_op(2, 40'd64, 40'd8);
    req_valid = 4'b0100;
    wait_grant("rstmid_grant", 4'b0100);
    @(negedge clk);
    req_valid = '0;
    n = 0;
    while (div_reset && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_in_run", 64'(state_dbg), 64'(2));
    reset = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy), 64'(0));
    check("rstmid_div_reset", 64'(div_reset), 64'(1));
    check("rstmid_div_ops", 64'({div_dividendo, div_divisor} != '0), 64'(0));
    check("rstmid_rsp", 64'({rsp_valid, rsp_id, rsp_status, rsp_result != '0}), 64'(0));
    repeat (3) begin
      @(negedge clk);
      check("rstmid_hold_valid", 64'(rsp_valid), 64'(0));
    end
    reset = 1'b1;
    set_op(0, 40'd20, 40'd4);
    set_op(1, 40'd30, 40'd3);
    req_valid = 4'b0011;
    push_exp(2'b00, 2'd0, 40'd5);
    wait_grant("rstmid_new_grant", 4'b0001);
    wait_resp("rstmid_new_rsp", n);
    req_valid = '0;
    @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
